// File: rtl/push_pkg.sv
// Shared definitions for the push-button conditioner: channel FSM states,
// synchronizer depth and a constant-width helper.
package push_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      S_REL    = 2'd0,
      S_DN_CHK = 2'd1,
      S_PRS    = 2'd2,
      S_UP_CHK = 2'd3
   } push_state_t;

   // Bits needed to hold values 0 .. value-1 (at least 1 bit)
   function automatic int clog2_f(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/push_deb_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM, press/release
// pulse generation and optional auto-repeat.
module push_deb_chan
   import push_pkg::*;
#(
   parameter int DEB_CYC    = 16,
   parameter int REPEAT_DLY = 0,
   parameter int REPEAT_PER = 8
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Push_raw,
   output logic o_Push,
   output logic o_Press,
   output logic o_Release,
   output logic o_Held
);

   localparam int DEB_W   = clog2_f(DEB_CYC + 1);
   localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int REP_W   = clog2_f(REP_MAX + 1);

   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC);
   localparam logic [REP_W-1:0] REP_DLY_C = REP_W'(REPEAT_DLY);
   localparam logic [REP_W-1:0] REP_PER_C = REP_W'(REPEAT_PER);
   localparam logic             REPEAT_EN = (REPEAT_DLY > 0);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sample_s;

   push_state_t      state_r,    state_s;
   logic [DEB_W-1:0] deb_cnt_r,  deb_cnt_s;
   logic [REP_W-1:0] rep_cnt_r,  rep_cnt_s;
   logic             push_r,     push_s;
   logic             press_r,    press_s;
   logic             release_r,  release_s;
   logic             held_r,     held_s;

   logic [REP_W-1:0] rep_inc_s;
   logic [REP_W-1:0] rep_thr_s;
   logic             rep_hit_s;

   // Bring the asynchronous pin into the clock domain (idle level = released)
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], i_Push_raw};
      end
   end

   assign sample_s  = sync_r[SYNC_STAGES-1];

   // The first repeat waits REPEAT_DLY held cycles, later ones REPEAT_PER;
   // held_r doubles as the phase flag and the counter restarts on each pulse.
   assign rep_inc_s = rep_cnt_r + REP_W'(1);
   assign rep_thr_s = held_r ? REP_PER_C : REP_DLY_C;
   assign rep_hit_s = REPEAT_EN && (rep_inc_s == rep_thr_s);

   // Next-state and next-output logic for the debounce / repeat FSM
   always_comb begin
      state_s   = state_r;
      deb_cnt_s = deb_cnt_r;
      rep_cnt_s = rep_cnt_r;
      push_s    = push_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      held_s    = held_r;
      case (state_r)
         S_REL: begin
            push_s = 1'b1;
            if (!sample_s) begin
               state_s   = S_DN_CHK;
               deb_cnt_s = DEB_W'(1);
            end else begin
               deb_cnt_s = DEB_W'(0);
            end
         end
         S_DN_CHK: begin
            if (sample_s) begin
               state_s   = S_REL;
               deb_cnt_s = DEB_W'(0);
            end else if (deb_cnt_r < DEB_LAST) begin
               deb_cnt_s = deb_cnt_r + DEB_W'(1);
            end else begin
               state_s   = S_PRS;
               deb_cnt_s = DEB_W'(0);
               rep_cnt_s = REP_W'(0);
               push_s    = 1'b0;
               press_s   = 1'b1;
            end
         end
         S_PRS: begin
            push_s = 1'b0;
            if (sample_s) begin
               // Leaving for the release check freezes the repeat counter
               state_s   = S_UP_CHK;
               deb_cnt_s = DEB_W'(1);
            end else if (REPEAT_EN) begin
               if (rep_hit_s) begin
                  press_s   = 1'b1;
                  held_s    = 1'b1;
                  rep_cnt_s = REP_W'(0);
               end else begin
                  rep_cnt_s = rep_inc_s;
               end
            end else begin
               rep_cnt_s = REP_W'(0);
            end
         end
         S_UP_CHK: begin
            push_s = 1'b0;
            if (!sample_s) begin
               state_s   = S_PRS;
               deb_cnt_s = DEB_W'(0);
            end else if (deb_cnt_r < DEB_LAST) begin
               deb_cnt_s = deb_cnt_r + DEB_W'(1);
            end else begin
               state_s   = S_REL;
               deb_cnt_s = DEB_W'(0);
               rep_cnt_s = REP_W'(0);
               push_s    = 1'b1;
               release_s = 1'b1;
               held_s    = 1'b0;
            end
         end
         default: begin
            state_s   = S_REL;
            deb_cnt_s = DEB_W'(0);
            rep_cnt_s = REP_W'(0);
            push_s    = 1'b1;
            held_s    = 1'b0;
         end
      endcase
   end

   // FSM state, counters and registered outputs
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_r   <= S_REL;
         deb_cnt_r <= DEB_W'(0);
         rep_cnt_r <= REP_W'(0);
         push_r    <= 1'b1;
         press_r   <= 1'b0;
         release_r <= 1'b0;
         held_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         deb_cnt_r <= deb_cnt_s;
         rep_cnt_r <= rep_cnt_s;
         push_r    <= push_s;
         press_r   <= press_s;
         release_r <= release_s;
         held_r    <= held_s;
      end
   end

   assign o_Push    = push_r;
   assign o_Press   = press_r;
   assign o_Release = release_r;
   assign o_Held    = held_r;

endmodule

// File: rtl/push_conditioner.sv
// Board push-button front end: one independent debounce channel per button,
// outputs concatenated into NUM_BTN-wide buses.
module push_conditioner
   import push_pkg::*;
#(
   parameter int NUM_BTN    = 2,
   parameter int DEB_CYC    = 16,
   parameter int REPEAT_DLY = 0,
   parameter int REPEAT_PER = 8
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic [NUM_BTN-1:0] i_Push_raw,
   output logic [NUM_BTN-1:0] o_Push,
   output logic [NUM_BTN-1:0] o_Press,
   output logic [NUM_BTN-1:0] o_Release,
   output logic [NUM_BTN-1:0] o_Held
);

   for (genvar g = 0; g < NUM_BTN; g++) begin : gen_chan
      push_deb_chan #(
         .DEB_CYC   (DEB_CYC),
         .REPEAT_DLY(REPEAT_DLY),
         .REPEAT_PER(REPEAT_PER)
      ) u_chan (
         .i_Clk     (i_Clk),
         .i_Rst     (i_Rst),
         .i_Push_raw(i_Push_raw[g]),
         .o_Push    (o_Push[g]),
         .o_Press   (o_Press[g]),
         .o_Release (o_Release[g]),
         .o_Held    (o_Held[g])
      );
   end

endmodule

// File: tb/tb_push_conditioner.sv
// Self-checking bench: two conditioners (auto-repeat on / off) share the same
// random and directed pin activity and are compared every cycle against a
// run-length based reference model.
module tb_push_conditioner;

   localparam int DEB = 4;
   localparam int PER = 8;
   localparam int DLY_A = 20;
   localparam int DLY_B = 0;

   logic       clk;
   logic       rst;
   logic [1:0] raw;
   logic [1:0] push_a, press_a, rel_a, held_a;
   logic [1:0] push_b, press_b, rel_b, held_b;

   int checks;
   int errors;
   int cyc;

   // reference model state, indexed [config][channel]
   bit m_s1[2][2], m_s2[2][2];
   bit m_pressed[2][2], m_held[2][2], m_press[2][2], m_rel[2][2];
   int m_run[2][2], m_active[2][2];
   int m_dly[2];

   push_conditioner #(.NUM_BTN(2), .DEB_CYC(DEB), .REPEAT_DLY(DLY_A), .REPEAT_PER(PER)) dut_a (
      .i_Clk(clk), .i_Rst(rst), .i_Push_raw(raw),
      .o_Push(push_a), .o_Press(press_a), .o_Release(rel_a), .o_Held(held_a));

   push_conditioner #(.NUM_BTN(2), .DEB_CYC(DEB), .REPEAT_DLY(DLY_B), .REPEAT_PER(PER)) dut_b (
      .i_Clk(clk), .i_Rst(rst), .i_Push_raw(raw),
      .o_Push(push_b), .o_Press(press_b), .o_Release(rel_b), .o_Held(held_b));

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         for (int b = 0; b < 2; b++) begin
            m_s1[c][b] = 1'b1;  m_s2[c][b] = 1'b1;
            m_pressed[c][b] = 1'b0; m_held[c][b] = 1'b0;
            m_press[c][b] = 1'b0;   m_rel[c][b] = 1'b0;
            m_run[c][b] = 0;        m_active[c][b] = 0;
         end
      end
   endtask

   // One clock edge: accept a level once DEB+1 consecutive opposite synced
   // samples are seen; count settled pressed cycles for the repeat schedule.
   task automatic model_step(input logic [1:0] raw_v);
      bit s;
      for (int c = 0; c < 2; c++) begin
         for (int b = 0; b < 2; b++) begin
            s = m_s2[c][b];
            m_s2[c][b] = m_s1[c][b];
            m_s1[c][b] = raw_v[b];
            m_press[c][b] = 1'b0;
            m_rel[c][b] = 1'b0;
            if (!m_pressed[c][b]) begin
               m_run[c][b] = (s == 1'b0) ? m_run[c][b] + 1 : 0;
               if (m_run[c][b] == DEB + 1) begin
                  m_pressed[c][b] = 1'b1; m_press[c][b] = 1'b1;
                  m_run[c][b] = 0; m_active[c][b] = 0;
               end
            end else if (s == 1'b1) begin
               m_run[c][b]++;
               if (m_run[c][b] == DEB + 1) begin
                  m_pressed[c][b] = 1'b0; m_rel[c][b] = 1'b1; m_held[c][b] = 1'b0;
                  m_run[c][b] = 0; m_active[c][b] = 0;
               end
            end else begin
               if (m_run[c][b] == 0) begin
                  m_active[c][b]++;
                  if (m_dly[c] > 0 && (m_active[c][b] == m_dly[c] ||
                      (m_active[c][b] > m_dly[c] && (m_active[c][b] - m_dly[c]) % PER == 0))) begin
                     m_press[c][b] = 1'b1;
                     m_held[c][b] = 1'b1;
                  end
               end
               m_run[c][b] = 0;
            end
         end
      end
   endtask

   task automatic check_outputs();
      logic [1:0] e_push[2], e_press[2], e_rel[2], e_held[2];
      for (int c = 0; c < 2; c++) begin
         for (int b = 0; b < 2; b++) begin
            e_push[c][b]  = ~m_pressed[c][b];
            e_press[c][b] = m_press[c][b];
            e_rel[c][b]   = m_rel[c][b];
            e_held[c][b]  = m_held[c][b];
         end
      end
      check_eq("a.push",    32'(push_a),  32'(e_push[0]));
      check_eq("a.press",   32'(press_a), 32'(e_press[0]));
      check_eq("a.release", 32'(rel_a),   32'(e_rel[0]));
      check_eq("a.held",    32'(held_a),  32'(e_held[0]));
      check_eq("b.push",    32'(push_b),  32'(e_push[1]));
      check_eq("b.press",   32'(press_b), 32'(e_press[1]));
      check_eq("b.release", 32'(rel_b),   32'(e_rel[1]));
      check_eq("b.held",    32'(held_b),  32'(e_held[1]));
   endtask

   // drive at the falling edge, model the rising edge, check at the next fall
   task automatic run_cycle(input logic [1:0] raw_v);
      raw = raw_v;
      @(posedge clk);
      model_step(raw_v);
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic hold(input logic [1:0] raw_v, input int n);
      for (int i = 0; i < n; i++) run_cycle(raw_v);
   endtask

   // asynchronous reset pulse placed between clock edges
   task automatic reset_mid();
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      int first_press, first_held, n_press_a, n_press_b, seg_len;
      logic [1:0] lvl;
      checks = 0; errors = 0; cyc = 0;
      m_dly[0] = DLY_A; m_dly[1] = DLY_B;
      raw = 2'b11;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs();
      rst = 1'b0;
      hold(2'b11, 3);

      // clean press on channel 0 with auto-repeat, edge index counted from first low sample
      first_press = -1; first_held = -1; n_press_a = 0; n_press_b = 0;
      for (int k = 0; k < 50; k++) begin
         run_cycle(2'b10);
         if (press_a[0] && first_press < 0) first_press = k;
         if (held_a[0] && first_held < 0) first_held = k;
         if (press_a[0]) n_press_a++;
         if (press_b[0]) n_press_b++;
      end
      check_eq("press_latency", 32'(first_press), 32'd6);
      check_eq("held_edge", 32'(first_held), 32'd26);
      check_eq("repeat_count_a", 32'(n_press_a), 32'd4);
      check_eq("repeat_count_b", 32'(n_press_b), 32'd1);
      hold(2'b11, 10);

      // bounce rejected, then a real press
      hold(2'b10, 3); hold(2'b11, 1); hold(2'b10, 3); hold(2'b11, 8);
      hold(2'b10, 30);
      // release bounce while held, then real release
      hold(2'b11, 2); hold(2'b10, 40); hold(2'b11, 10);

      // simultaneous press/release of both channels
      hold(2'b00, 30); hold(2'b11, 10);

      // reset during press debounce and again while held
      hold(2'b00, 3); reset_mid();
      hold(2'b00, 25); reset_mid();
      hold(2'b00, 12); hold(2'b11, 10);

      // random bouncing activity
      for (int seg = 0; seg < 300; seg++) begin
         lvl = 2'($urandom_range(0, 3));
         seg_len = $urandom_range(1, 40);
         for (int i = 0; i < seg_len; i++) begin
            if ($urandom_range(0, 19) == 0) run_cycle(~lvl);
            else run_cycle(lvl);
         end
         if ($urandom_range(0, 49) == 0) reset_mid();
      end
      hold(2'b11, 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
